bubble_sort_ctrl: RTL and testbench
===================================

BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

Interface
REQ-001 SHALL have parameter datawidth, default 8, the element width in bits.
REQ-002 SHALL have parameter depth, default 8, the maximum element count (at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1 bit: load_data is valid this cycle.
REQ-006 SHALL have port load_data, input, datawidth bits: element to append.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept a load this cycle.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear of the element count.
REQ-009 SHALL have port start, input, 1 bit: begin sorting the loaded elements.
REQ-010 SHALL have port busy, output, 1 bit: a sort is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a sort completes.
REQ-012 SHALL have port cmp_a, output, datawidth bits: left operand to the external comparator.
REQ-013 SHALL have port cmp_b, output, datawidth bits: right operand to the external comparator.
REQ-014 SHALL have port cmp_gt, input, 1 bit: comparator result, cmp_a > cmp_b (combinational, same cycle).
REQ-015 SHALL have port rd_addr, input, clog2(depth) bits: read index.
REQ-016 SHALL have port rd_data, output, datawidth bits: combinational read of element rd_addr.

Function
REQ-017 SHALL implement states IDLE, COMPARE, SWAP and DONE.
REQ-018 SHALL drive load_ready = 1 only in IDLE when count < depth.
REQ-019 SHALL, on load_valid && load_ready, write mem[count] = load_data and increment count.
REQ-020 SHALL, on clr in IDLE, set count to 0; clr SHALL take priority over a same-cycle load or start; clr outside IDLE SHALL be ignored.
REQ-021 SHALL, on start in IDLE with count >= 2, set j = 0, last = count-1 and swapped = 0, then enter COMPARE.
REQ-022 SHALL, on start in IDLE with count < 2, go directly to DONE.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL drive cmp_a = mem[j] and cmp_b = mem[j+1] in every state; both SHALL be 0 after reset.
REQ-025 SHALL, in COMPARE with cmp_gt = 1, go to SWAP; with cmp_gt = 0 it SHALL advance.
REQ-026 SHALL, in SWAP, exchange mem[j] and mem[j+1], set swapped = 1 and advance, all in one cycle.
REQ-027 SHALL, on advance with j < last-1, increment j and go to COMPARE.
REQ-028 SHALL, on advance with j = last-1 (end of pass), go to DONE when last = 1 or the early-exit condition holds; otherwise it SHALL set last = last-1, j = 0, swapped = 0 and go to COMPARE.
REQ-029 SHALL never swap equal elements, so the sort is stable.
REQ-030 SHALL hold DONE for exactly one cycle with done = 1, then return to IDLE; count and sorted contents SHALL be retained.
REQ-031 SHALL drive busy = 1 exactly in COMPARE and SWAP.
REQ-032 SHALL time the sort as follows: 1 cycle per comparison plus 1 per swap; first COMPARE the cycle after start is accepted; DONE the cycle after the final advance.

Reset
REQ-033 SHALL, while rst_n = 0, asynchronously force state = IDLE, count = 0, j = 0, last = 0, swapped = 0, busy = 0 and done = 0.
REQ-034 SHALL make load_ready = 1 from the first edge after reset release.
REQ-035 SHALL abandon a sort if reset asserts mid-sort; mem contents are not reset and are undefined for test purposes.

Configuration
REQ-036 SHALL, with macro BUBBLE_SORT_EARLY_EXIT_EN defined, treat swapped = 0 at end of pass as the early-exit condition and go to DONE.
REQ-037 SHALL, without BUBBLE_SORT_EARLY_EXIT_EN, always run count-1 passes and ignore swapped for termination.

Verification
REQ-038 SHALL cover: load 5,1,4,2, start -> done pulse; rd_addr 0..3 reads 1,2,4,5; busy high throughout the sort.
REQ-039 SHALL cover: load 1,2,3,4, start -> done after 3 COMPARE cycles with the macro, after 6 without it, with no SWAP cycles in either case.
REQ-040 SHALL cover: load 8 elements, then a 9th with load_valid = 1 -> load_ready = 0, 9th not written, count stays 8.
REQ-041 SHALL cover: load 3,3,1 with tagged-order checks -> result 1,3,3 with no COMPARE->SWAP transition for the 3 vs 3 pair.
REQ-042 SHALL cover: count = 1, start -> done on the next cycle, busy never high; count = 0 behaves the same.
REQ-043 SHALL cover: rst_n pulsed low mid-sort -> busy = 0, done = 0, count = 0 immediately; new loads are accepted after release.

Source files
------------

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer over a small register file, using an external comparator.
// Define BUBBLE_SORT_EARLY_EXIT_EN to stop as soon as a full pass makes no swap.
module bubble_sort_ctrl #(
   parameter int datawidth = 8,
   parameter int depth     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_valid,
   input  logic [datawidth-1:0]       load_data,
   output logic                       load_ready,
   input  logic                       clr,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [datawidth-1:0]       cmp_a,
   output logic [datawidth-1:0]       cmp_b,
   input  logic                       cmp_gt,
   input  logic [$clog2(depth)-1:0]   rd_addr,
   output logic [datawidth-1:0]       rd_data
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth + 1);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, COMPARE, SWAP, DONE} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        count, count_nxt;
   logic [AW-1:0]        j, j_nxt;
   logic [AW-1:0]        last, last_nxt;
   logic                 swapped, swapped_nxt;
   logic [AW-1:0]        j1;
   logic [depth-1:0]     vld;
   logic [datawidth-1:0] mem [depth];
   logic                 load_fire;
   logic                 advance;
   logic                 pass_end;
   logic                 early_exit;

   assign j1         = j + AW'(1);
   assign load_ready = (state == IDLE) && (count < CW'(depth));
   assign load_fire  = load_valid && load_ready && !clr;
   assign busy       = (state == COMPARE) || (state == SWAP);
   assign done       = (state == DONE);
   // j never exceeds last-1, so j+1 == last marks the final pair of a pass
   assign pass_end   = (j1 == last);
   // a swap in progress counts as a swap for this pass
   assign early_exit = EARLY_EN && !(swapped || (state == SWAP));

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      j_nxt       = j;
      last_nxt    = last;
      swapped_nxt = swapped;
      advance     = 1'b0;
      case (state)
         IDLE: begin
            if (clr) begin
               count_nxt = '0;
            end else begin
               if (load_fire)
                  count_nxt = count + CW'(1);
               if (start) begin
                  if (count >= CW'(2)) begin
                     j_nxt       = '0;
                     last_nxt    = AW'(count - CW'(1));
                     swapped_nxt = 1'b0;
                     state_nxt   = COMPARE;
                  end else begin
                     state_nxt = DONE;
                  end
               end
            end
         end
         COMPARE: begin
            if (cmp_gt)
               state_nxt = SWAP;
            else
               advance = 1'b1;
         end
         SWAP: begin
            swapped_nxt = 1'b1;
            advance     = 1'b1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (advance) begin
         if (!pass_end) begin
            j_nxt     = j1;
            state_nxt = COMPARE;
         end else if ((last == AW'(1)) || early_exit) begin
            state_nxt = DONE;
         end else begin
            last_nxt    = last - AW'(1);
            j_nxt       = '0;
            swapped_nxt = 1'b0;
            state_nxt   = COMPARE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         j       <= '0;
         last    <= '0;
         swapped <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         j       <= j_nxt;
         last    <= last_nxt;
         swapped <= swapped_nxt;
      end
   end

   // Per-slot written flags keep the comparator lanes at zero until data exists
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld <= '0;
      else if (load_fire)
         vld[AW'(count)] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (load_fire) begin
         mem[AW'(count)] <= load_data;
      end else if (state == SWAP) begin
         mem[j]  <= mem[j1];
         mem[j1] <= mem[j];
      end
   end

   assign cmp_a   = vld[j]  ? mem[j]  : '0;
   assign cmp_b   = vld[j1] ? mem[j1] : '0;
   assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed self-checking bench for bubble_sort_ctrl; the comparator looks only at
// data[7:2], leaving data[1:0] free as an order tag for stability checks.
module tb_bubble_sort_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_valid = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          load_ready;
   logic          clr = 1'b0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic [DW-1:0] cmp_a;
   logic [DW-1:0] cmp_b;
   logic          cmp_gt;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   bubble_sort_ctrl #(.datawidth(DW), .depth(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .clr        (clr),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .cmp_a      (cmp_a),
      .cmp_b      (cmp_b),
      .cmp_gt     (cmp_gt),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   assign cmp_gt = (cmp_a[7:2] > cmp_b[7:2]);

   always #5 clk = ~clk;

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   localparam int SORTED_BUSY = 3;
`else
   localparam int SORTED_BUSY = 6;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [DW-1:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_clr;
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic expect_mem(input string tag, input int idx, input logic [DW-1:0] v);
      rd_addr = AW'(idx);
      tick();
      check(tag, 32'(rd_data), 32'(v));
   endtask

   // Starts a sort and follows it to the done pulse within a bounded cycle budget
   task automatic run_sort(input string tag, input int exp_busy, input int exp_eq,
                           input logic exp_rdy);
      int busy_n  = 0;
      int eq_n    = 0;
      int gap     = 0;
      int done_at = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         if (done) begin
            done_at = k;
            break;
         end
         if (busy) begin
            busy_n++;
            if (cmp_a[7:2] == cmp_b[7:2]) eq_n++;
         end else begin
            gap++;
         end
         tick();
      end
      check({tag, ".done_at"}, 32'(done_at), 32'(exp_busy + 1));
      check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      check({tag, ".busy_gap"}, 32'(gap), 32'd0);
      check({tag, ".eq_pairs"}, 32'(eq_n), 32'(exp_eq));
      check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      tick();
      check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
      check({tag, ".idle_ready"}, 32'(load_ready), 32'(exp_rdy));
   endtask

   initial begin
      #1;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.cmp_a", 32'(cmp_a), 32'd0);
      check("rst.cmp_b", 32'(cmp_b), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("rst.load_ready", 32'(load_ready), 32'd1);

      // 5,1,4,2 -> 1,2,4,5: 6 compares + 4 swaps
      load(8'd20); load(8'd4); load(8'd16); load(8'd8);
      run_sort("basic", 10, 0, 1'b1);
      expect_mem("basic.rd0", 0, 8'd4);
      expect_mem("basic.rd1", 1, 8'd8);
      expect_mem("basic.rd2", 2, 8'd16);
      expect_mem("basic.rd3", 3, 8'd20);

      // already sorted: compare-only cycles
      do_clr();
      load(8'd4); load(8'd8); load(8'd12); load(8'd16);
      run_sort("sorted", SORTED_BUSY, 0, 1'b1);
      expect_mem("sorted.rd0", 0, 8'd4);
      expect_mem("sorted.rd3", 3, 8'd16);

      // 3(tag0),3(tag1),1(tag2): equal pair compared once and never swapped
      do_clr();
      load(8'd12); load(8'd13); load(8'd6);
      run_sort("stable", 5, 1, 1'b1);
      expect_mem("stable.rd0", 0, 8'd6);
      expect_mem("stable.rd1", 1, 8'd12);
      expect_mem("stable.rd2", 2, 8'd13);

      // full buffer, then a refused 9th load
      do_clr();
      for (int i = 0; i < DEPTH; i++) load(8'(4 * (DEPTH - i)));
      check("full.load_ready", 32'(load_ready), 32'd0);
      load(8'd0);
      check("full.still_not_ready", 32'(load_ready), 32'd0);
      run_sort("full", 56, 0, 1'b0);
      expect_mem("full.rd0", 0, 8'd4);
      expect_mem("full.rd3", 3, 8'd16);
      expect_mem("full.rd7", 7, 8'd32);

      // clr beats a same-cycle load, leaving a single element
      do_clr();
      load(8'd44);
      clr        = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'd48;
      tick();
      clr        = 1'b0;
      load_valid = 1'b0;
      load(8'd40);
      run_sort("one", 0, 0, 1'b1);
      expect_mem("one.rd0", 0, 8'd40);

      do_clr();
      run_sort("zero", 0, 0, 1'b1);

      // clr beats a same-cycle start
      load(8'd24); load(8'd20);
      clr   = 1'b1;
      start = 1'b1;
      tick();
      clr   = 1'b0;
      start = 1'b0;
      check("clrstart.busy", 32'(busy), 32'd0);
      check("clrstart.done", 32'(done), 32'd0);

      // reset in the middle of a sort
      do_clr();
      load(8'd28); load(8'd24); load(8'd20); load(8'd16);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("mid.busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid.busy", 32'(busy), 32'd0);
      check("mid.done", 32'(done), 32'd0);
      check("mid.load_ready", 32'(load_ready), 32'd1);
      check("mid.cmp_a", 32'(cmp_a), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      check("post.load_ready", 32'(load_ready), 32'd1);
      load(8'd36); load(8'd12);
      run_sort("post", 2, 0, 1'b1);
      expect_mem("post.rd0", 0, 8'd12);
      expect_mem("post.rd1", 1, 8'd36);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
